// File: rtl/sc_timer_pkg.sv
// Shared types and constants for the RoadFighter game-time counter.
// State encodings are visible on the state bus, so they are fixed here.
package sc_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timerState_t;

    localparam int TIMER_TICKDIV_DEFAULT = 50000000;
    localparam int TIMER_TICKDIV_SIM     = 4;

endpackage

// File: rtl/sc_tick_prescaler.sv
// Free-running divider that flags its terminal count; it advances only
// while enabled and wraps to zero on the terminal count.
module sc_tick_prescaler
    import sc_timer_pkg::*;
#(
    parameter int TICKDIV  = TIMER_TICKDIV_DEFAULT,
    parameter int PREWIDTH = 26
) (
    input  logic SC_Prescaler_CLOCK_50,
    input  logic SC_Prescaler_RESET_InHigh,
    input  logic SC_Prescaler_ENABLE_InHigh,
    input  logic SC_Prescaler_CLEAR_InHigh,
    output logic SC_Prescaler_TICK_OutHigh
);

    localparam logic [PREWIDTH-1:0] PRE_TOP = PREWIDTH'(TICKDIV - 1);

    logic [PREWIDTH-1:0] preCount;

    // Raw terminal-count flag; the owner decides whether it is acted on.
    assign SC_Prescaler_TICK_OutHigh = (preCount == PRE_TOP);

    always_ff @(posedge SC_Prescaler_CLOCK_50 or posedge SC_Prescaler_RESET_InHigh) begin
        if (SC_Prescaler_RESET_InHigh) begin
            preCount <= '0;
        end else if (SC_Prescaler_CLEAR_InHigh) begin
            preCount <= '0;
        end else if (SC_Prescaler_ENABLE_InHigh) begin
            if (preCount == PRE_TOP) begin
                preCount <= '0;
            end else begin
                preCount <= preCount + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_reg_timer.sv
// Game-time counter: FSM, time register and direction/limit latches,
// stepping once per prescaler period while running.
module sc_reg_timer
    import sc_timer_pkg::*;
#(
    parameter int RegTIMER_DATAWIDTH = 8,
    parameter int RegTIMER_TICKDIV   = TIMER_TICKDIV_DEFAULT,
    parameter int RegTIMER_PREWIDTH  = 26
) (
    input  logic                          SC_RegTIMER_CLOCK_50,
    input  logic                          SC_RegTIMER_RESET_InHigh,
    input  logic                          SC_RegTIMER_START_InHigh,
    input  logic                          SC_RegTIMER_PAUSE_InHigh,
    input  logic                          SC_RegTIMER_CLEAR_InHigh,
    input  logic                          SC_RegTIMER_LOAD_InHigh,
    input  logic                          SC_RegTIMER_DOWN_InHigh,
    input  logic [RegTIMER_DATAWIDTH-1:0] SC_RegTIMER_data_InBUS,
    input  logic [RegTIMER_DATAWIDTH-1:0] SC_RegTIMER_limit_InBUS,
    output logic [RegTIMER_DATAWIDTH-1:0] SC_RegTIMER_data_OutBUS,
    output logic                          SC_RegTIMER_TICK_OutHigh,
    output logic                          SC_RegTIMER_DONE_OutHigh,
    output logic                          SC_RegTIMER_RUNNING_OutHigh,
    output logic [1:0]                    SC_RegTIMER_state_OutBUS
);

    timerState_t                   stateQ, stateD;
    logic [RegTIMER_DATAWIDTH-1:0] countQ, countD;
    logic [RegTIMER_DATAWIDTH-1:0] limitQ, limitD;
    logic [RegTIMER_DATAWIDTH-1:0] stepped, termSel;
    logic                          downQ, downD;
    logic                          tickQ, tickD;
    logic                          doneQ, doneD;
    logic                          preEnable, preClear, preTick;

    sc_tick_prescaler #(
        .TICKDIV  (RegTIMER_TICKDIV),
        .PREWIDTH (RegTIMER_PREWIDTH)
    ) u_prescaler (
        .SC_Prescaler_CLOCK_50      (SC_RegTIMER_CLOCK_50),
        .SC_Prescaler_RESET_InHigh  (SC_RegTIMER_RESET_InHigh),
        .SC_Prescaler_ENABLE_InHigh (preEnable),
        .SC_Prescaler_CLEAR_InHigh  (preClear),
        .SC_Prescaler_TICK_OutHigh  (preTick)
    );

    always_comb begin
        stateD    = stateQ;
        countD    = countQ;
        limitD    = limitQ;
        downD     = downQ;
        tickD     = 1'b0;
        doneD     = 1'b0;
        preEnable = 1'b0;
        preClear  = 1'b0;
        stepped   = countQ;
        termSel   = '0;
        if (SC_RegTIMER_CLEAR_InHigh) begin
            stateD   = ST_IDLE;
            countD   = '0;
            preClear = 1'b1;
        end else if (SC_RegTIMER_LOAD_InHigh) begin
            countD   = SC_RegTIMER_data_InBUS;
            preClear = 1'b1;
            if (stateQ == ST_DONE) begin
                stateD = ST_IDLE;
            end
        end else if (SC_RegTIMER_PAUSE_InHigh) begin
            if (stateQ == ST_RUN) begin
                stateD = ST_PAUSE;
            end
        end else if (SC_RegTIMER_START_InHigh && stateQ != ST_RUN) begin
            // Resuming from PAUSE keeps the latches and prescaler phase.
            if (stateQ != ST_PAUSE) begin
                downD    = SC_RegTIMER_DOWN_InHigh;
                limitD   = SC_RegTIMER_limit_InBUS;
                preClear = 1'b1;
            end
            termSel = downD ? '0 : limitD;
            if (countQ == termSel) begin
                stateD = ST_DONE;
                doneD  = 1'b1;
            end else begin
                stateD = ST_RUN;
            end
        end else if (stateQ == ST_RUN) begin
            preEnable = 1'b1;
            if (preTick) begin
                tickD   = 1'b1;
                stepped = downQ ? countQ - 1'b1 : countQ + 1'b1;
                termSel = downQ ? '0 : limitQ;
                countD  = stepped;
                if (stepped == termSel) begin
                    stateD = ST_DONE;
                    doneD  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge SC_RegTIMER_CLOCK_50 or posedge SC_RegTIMER_RESET_InHigh) begin
        if (SC_RegTIMER_RESET_InHigh) begin
            stateQ <= ST_IDLE;
            countQ <= '0;
            limitQ <= '0;
            downQ  <= 1'b0;
            tickQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            countQ <= countD;
            limitQ <= limitD;
            downQ  <= downD;
            tickQ  <= tickD;
            doneQ  <= doneD;
        end
    end

    assign SC_RegTIMER_data_OutBUS     = countQ;
    assign SC_RegTIMER_TICK_OutHigh    = tickQ;
    assign SC_RegTIMER_DONE_OutHigh    = doneQ;
    assign SC_RegTIMER_RUNNING_OutHigh = (stateQ == ST_RUN);
    assign SC_RegTIMER_state_OutBUS    = stateQ;

endmodule

// File: tb/tb_sc_reg_timer.sv
// Bench for sc_reg_timer: directed vector table, async reset sequence,
// then random control traffic against a cycle-level behavioural model.
module tb_sc_reg_timer;
    import sc_timer_pkg::*;

    localparam int TD = TIMER_TICKDIV_SIM;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, pause = 1'b0, clr = 1'b0, ld = 1'b0, down = 1'b0;
    logic [7:0] data = 8'd0, lim = 8'd0;
    logic [7:0] dOut;
    logic       tickO, doneO, runO;
    logic [1:0] stO;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 run, 2 pause, 3 done; phase counts run cycles.
    int mMode, mCnt, mPhase, mLim;
    bit mDown, mTick, mDone;

    typedef struct {
        bit s, p, c, l, d;
        int dv, lv, reps;
        int eCnt, eSt;
        bit eTick, eDone;
    } vec_t;

    vec_t tbl[$];

    sc_reg_timer #(
        .RegTIMER_DATAWIDTH (8),
        .RegTIMER_TICKDIV   (TD),
        .RegTIMER_PREWIDTH  (4)
    ) dut (
        .SC_RegTIMER_CLOCK_50        (clk),
        .SC_RegTIMER_RESET_InHigh    (rst),
        .SC_RegTIMER_START_InHigh    (start),
        .SC_RegTIMER_PAUSE_InHigh    (pause),
        .SC_RegTIMER_CLEAR_InHigh    (clr),
        .SC_RegTIMER_LOAD_InHigh     (ld),
        .SC_RegTIMER_DOWN_InHigh     (down),
        .SC_RegTIMER_data_InBUS      (data),
        .SC_RegTIMER_limit_InBUS     (lim),
        .SC_RegTIMER_data_OutBUS     (dOut),
        .SC_RegTIMER_TICK_OutHigh    (tickO),
        .SC_RegTIMER_DONE_OutHigh    (doneO),
        .SC_RegTIMER_RUNNING_OutHigh (runO),
        .SC_RegTIMER_state_OutBUS    (stO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int term();
        return mDown ? 0 : mLim;
    endfunction

    task automatic modelReset();
        mMode = 0; mCnt = 0; mPhase = 0; mLim = 0;
        mDown = 0; mTick = 0; mDone = 0;
    endtask

    task automatic modelStep();
        mTick = 0;
        mDone = 0;
        if (clr) begin
            mMode = 0; mCnt = 0; mPhase = 0;
        end else if (ld) begin
            mCnt = int'(data); mPhase = 0;
            if (mMode == 3) mMode = 0;
        end else if (pause) begin
            if (mMode == 1) mMode = 2;
        end else if (start && mMode != 1) begin
            if (mMode != 2) begin
                mDown = down; mLim = int'(lim); mPhase = 0;
            end
            if (mCnt == term()) begin
                mMode = 3; mDone = 1;
            end else begin
                mMode = 1;
            end
        end else if (mMode == 1) begin
            mPhase++;
            if (mPhase == TD) begin
                mPhase = 0;
                mTick = 1;
                mCnt = mDown ? (mCnt + 255) % 256 : (mCnt + 1) % 256;
                if (mCnt == term()) begin
                    mMode = 3; mDone = 1;
                end
            end
        end
    endtask

    task automatic compareModel();
        check("model count", int'(dOut), mCnt);
        check("model tick", int'(tickO), int'(mTick));
        check("model done", int'(doneO), int'(mDone));
        check("model running", int'(runO), (mMode == 1) ? 1 : 0);
        check("model state", int'(stO), mMode);
    endtask

    task automatic applyCycle(input bit s, p, c, l, d, input int dv, lv);
        start = s; pause = p; clr = c; ld = l; down = d;
        data = dv[7:0]; lim = lv[7:0];
        @(posedge clk);
        modelStep();
        #1;
        compareModel();
        start = 0; pause = 0; clr = 0; ld = 0;
    endtask

    function automatic void addVec(input bit s, p, c, l, d, input int dv, lv,
                                   reps, eCnt, eSt, input bit eTick, eDone);
        vec_t v;
        v.s = s; v.p = p; v.c = c; v.l = l; v.d = d;
        v.dv = dv; v.lv = lv; v.reps = reps;
        v.eCnt = eCnt; v.eSt = eSt; v.eTick = eTick; v.eDone = eDone;
        tbl.push_back(v);
    endfunction

    initial begin
        // Up to limit 3
        addVec(1,0,0,0,0, 0,3, 1,  0,1,0,0);
        addVec(0,0,0,0,0, 0,3, 3,  0,1,0,0);
        addVec(0,0,0,0,0, 0,3, 1,  1,1,1,0);
        addVec(0,0,0,0,0, 0,3, 4,  2,1,1,0);
        addVec(0,0,0,0,0, 0,3, 4,  3,3,1,1);
        addVec(0,0,0,0,0, 0,3, 20, 3,3,0,0);
        // Down from 2
        addVec(0,0,0,1,1, 2,0, 1,  2,0,0,0);
        addVec(1,0,0,0,1, 0,0, 1,  2,1,0,0);
        addVec(0,0,0,0,1, 0,0, 4,  1,1,1,0);
        addVec(0,0,0,0,1, 0,0, 4,  0,3,1,1);
        addVec(0,0,0,0,1, 0,0, 1,  0,3,0,0);
        // Pause and resume mid-period
        addVec(0,0,1,0,0, 0,9, 1,  0,0,0,0);
        addVec(1,0,0,0,0, 0,9, 1,  0,1,0,0);
        addVec(0,0,0,0,0, 0,9, 4,  1,1,1,0);
        addVec(0,0,0,0,0, 0,9, 2,  1,1,0,0);
        addVec(0,1,0,0,0, 0,9, 10, 1,2,0,0);
        addVec(1,0,0,0,0, 0,9, 1,  1,1,0,0);
        addVec(0,0,0,0,0, 0,9, 1,  1,1,0,0);
        addVec(0,0,0,0,0, 0,9, 1,  2,1,1,0);
        // Collisions
        addVec(1,1,0,0,0, 0,9, 1,  2,2,0,0);
        addVec(1,0,0,0,0, 0,9, 1,  2,1,0,0);
        addVec(0,0,0,0,0, 0,9, 3,  2,1,0,0);
        addVec(0,0,0,1,0, 'h55,9, 1, 'h55,1,0,0);
        addVec(0,0,1,1,0, 'h77,9, 1, 0,0,0,0);
        addVec(1,1,0,0,0, 0,9, 1,  0,0,0,0);
        // Already at terminal, and wrap past 0xFF
        addVec(1,0,0,0,0, 0,0, 1,  0,3,0,1);
        addVec(0,0,0,0,0, 0,0, 1,  0,3,0,0);
        addVec(0,0,0,1,0, 'hFF,1, 1, 'hFF,0,0,0);
        addVec(1,0,0,0,0, 0,1, 1,  'hFF,1,0,0);
        addVec(0,0,0,0,0, 0,1, 4,  0,1,1,0);
        addVec(0,0,0,0,0, 0,1, 4,  1,3,1,1);

        modelReset();
        #12;
        check("reset count", int'(dOut), 0);
        check("reset state", int'(stO), 0);
        check("reset running", int'(runO), 0);
        check("reset tick", int'(tickO), 0);
        check("reset done", int'(doneO), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                if (r == 0)
                    applyCycle(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].l,
                               tbl[i].d, tbl[i].dv, tbl[i].lv);
                else
                    applyCycle(0, 0, 0, 0, tbl[i].d, tbl[i].dv, tbl[i].lv);
            end
            check($sformatf("vec%0d count", i), int'(dOut), tbl[i].eCnt);
            check($sformatf("vec%0d state", i), int'(stO), tbl[i].eSt);
            check($sformatf("vec%0d tick", i), int'(tickO), int'(tbl[i].eTick));
            check($sformatf("vec%0d done", i), int'(doneO), int'(tbl[i].eDone));
            check($sformatf("vec%0d running", i), int'(runO),
                  (tbl[i].eSt == 1) ? 1 : 0);
        end

        // Async reset between edges while running with a nonzero count
        applyCycle(0, 0, 1, 0, 0, 0, 0);
        applyCycle(1, 0, 0, 0, 0, 0, 7);
        for (int k = 0; k < 5; k++) applyCycle(0, 0, 0, 0, 0, 0, 7);
        check("pre-reset count", int'(dOut), 1);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        check("async count", int'(dOut), 0);
        check("async state", int'(stO), 0);
        check("async running", int'(runO), 0);
        check("async tick", int'(tickO), 0);
        @(negedge clk);
        rst = 1'b0;
        applyCycle(1, 0, 0, 0, 0, 0, 2);
        for (int k = 0; k < 3; k++) applyCycle(0, 0, 0, 0, 0, 0, 2);
        check("post-reset no early tick", int'(tickO), 0);
        applyCycle(0, 0, 0, 0, 0, 0, 2);
        check("post-reset first tick", int'(tickO), 1);
        check("post-reset count", int'(dOut), 1);

        // Random control traffic
        for (int n = 0; n < 4000; n++) begin
            bit s, p, c, l, d;
            s = ($urandom_range(0, 99) < 10);
            p = ($urandom_range(0, 99) < 5);
            c = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 3);
            d = $urandom_range(0, 1) == 1;
            applyCycle(s, p, c, l, d, int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 12)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
